// File: rtl/mux_scan_pkg.sv
// Shared constants and state encoding for the 4:1 selector scan sequencer.
package mux_scan_pkg;

   localparam int unsigned NUM_CH     = 4;
   localparam int unsigned SEL_W      = 2;
   localparam int unsigned CNT_W      = 4;
   localparam int unsigned SETTLE_MAX = 15;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t HOLD = 2'd1;
   localparam state_t DONE = 2'd2;

endpackage

// File: rtl/mux_scan_ctrl_next_ch_find.sv
// Finds the next enabled channel above cur, or the lowest enabled one when first is set.
module next_ch_find
   import mux_scan_pkg::*;
(
   input  logic [NUM_CH-1:0] mask,
   input  logic [SEL_W-1:0]  cur,
   input  logic              first,
   output logic [SEL_W-1:0]  next_c,
   output logic              found_c
);

   // Descending walk so the lowest qualifying channel is the last one written.
   always_comb begin
      next_c  = '0;
      found_c = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask[i] && (first || (SEL_W'(i) > cur))) begin
            next_c  = SEL_W'(i);
            found_c = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps the 4:1 selector through its enabled channels, settles, captures y and
// reports the four captured bits as one word with a single-cycle valid pulse.
module mux_scan_ctrl
   import mux_scan_pkg::*;
#(
   parameter int unsigned SETTLE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              cont,
   input  logic [NUM_CH-1:0] en_mask,
   input  logic              y,
   output logic              s0,
   output logic              s1,
   output logic [NUM_CH-1:0] sample,
   output logic              valid,
   output logic              busy
);

   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);

   state_t            state, state_n;
   logic [SEL_W-1:0]  sel, sel_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [NUM_CH-1:0] mask, mask_n;
   logic [NUM_CH-1:0] shadow, shadow_n;
   logic [NUM_CH-1:0] sample_n;
   logic              valid_n, busy_n;

   logic [NUM_CH-1:0] find_mask;
   logic              find_first;
   logic [SEL_W-1:0]  find_ch;
   logic              find_ok;

   // IDLE searches the live mask; DONE restarts from the latched mask.
   assign find_mask  = (state == IDLE) ? en_mask : mask;
   assign find_first = (state != HOLD);

   next_ch_find u_find (
      .mask    (find_mask),
      .cur     (sel),
      .first   (find_first),
      .next_c  (find_ch),
      .found_c (find_ok)
   );

   assign s0 = sel[1];
   assign s1 = sel[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         sel    <= '0;
         cnt    <= '0;
         mask   <= '0;
         shadow <= '0;
         sample <= '0;
         valid  <= 1'b0;
         busy   <= 1'b0;
      end else begin
         state  <= state_n;
         sel    <= sel_n;
         cnt    <= cnt_n;
         mask   <= mask_n;
         shadow <= shadow_n;
         sample <= sample_n;
         valid  <= valid_n;
         busy   <= busy_n;
      end
   end

   always_comb begin
      state_n  = state;
      sel_n    = sel;
      cnt_n    = cnt;
      mask_n   = mask;
      shadow_n = shadow;
      sample_n = sample;
      valid_n  = 1'b0;
      busy_n   = busy;

      case (state)
         IDLE: begin
            sel_n  = '0;
            busy_n = 1'b0;
            if (start) begin
               mask_n   = en_mask;
               shadow_n = '0;
               busy_n   = 1'b1;
               if (find_ok) begin
                  state_n = HOLD;
                  sel_n   = find_ch;
                  cnt_n   = SETTLE_LD;
               end else begin
                  state_n = DONE;
               end
            end
         end

         HOLD: begin
            busy_n = 1'b1;
            if (cnt != '0) begin
               cnt_n = cnt - 1'b1;
            end else begin
               shadow_n[sel] = y;
               if (find_ok) begin
                  sel_n = find_ch;
                  cnt_n = SETTLE_LD;
               end else begin
                  state_n = DONE;
               end
            end
         end

         DONE: begin
            sample_n = shadow;
            valid_n  = 1'b1;
            busy_n   = 1'b0;
            if (cont) begin
               shadow_n = '0;
               if (find_ok) begin
                  state_n = HOLD;
                  sel_n   = find_ch;
                  cnt_n   = SETTLE_LD;
               end else begin
                  state_n = DONE;
               end
            end else begin
               state_n = IDLE;
               sel_n   = '0;
            end
         end

         default: begin
            state_n = IDLE;
            sel_n   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Randomised and directed bench for mux_scan_ctrl; instance 0 uses SETTLE=1, instance 1 SETTLE=0.
module tb_mux_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_r [2];
   logic       cont_r  [2];
   logic [3:0] en_mask;
   logic [3:0] din;

   logic       s0_w    [2];
   logic       s1_w    [2];
   logic       y_w     [2];
   logic       valid_w [2];
   logic       busy_w  [2];
   logic [3:0] sample_w[2];
   logic [1:0] sel_w   [2];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   // Behavioural stand-in for the 4:1 selector: channel {s0,s1} drives y.
   for (genvar g = 0; g < 2; g++) begin : g_sel
      assign sel_w[g] = {s0_w[g], s1_w[g]};
      assign y_w[g]   = din[sel_w[g]];
   end

   mux_scan_ctrl #(.SETTLE(1)) dut_a (
      .clk(clk), .rst(rst), .start(start_r[0]), .cont(cont_r[0]), .en_mask(en_mask),
      .y(y_w[0]), .s0(s0_w[0]), .s1(s1_w[0]), .sample(sample_w[0]),
      .valid(valid_w[0]), .busy(busy_w[0])
   );

   mux_scan_ctrl #(.SETTLE(0)) dut_b (
      .clk(clk), .rst(rst), .start(start_r[1]), .cont(cont_r[1]), .en_mask(en_mask),
      .y(y_w[1]), .s0(s0_w[1]), .s1(s1_w[1]), .sample(sample_w[1]),
      .valid(valid_w[1]), .busy(busy_w[1])
   );

   function automatic int n_en(input logic [3:0] m);
      int n = 0;
      for (int i = 0; i < 4; i++) if (m[i]) n++;
      return n;
   endfunction

   // k-th enabled channel in ascending order.
   function automatic int ch_at(input logic [3:0] m, input int k);
      int seen = 0;
      for (int i = 0; i < 4; i++) begin
         if (m[i]) begin
            if (seen == k) return i;
            seen++;
         end
      end
      return 0;
   endfunction

   // One scan from a start pulse; optionally re-pulses start and flips en_mask mid-scan.
   task automatic run_scan(input int inst, input logic [3:0] m, input bit disturb, input string name);
      int         s   = (inst == 0) ? 1 : 0;
      int         n   = n_en(m);
      int         lat = n * (s + 1) + 1;
      int         ch;
      logic [3:0] exp = 4'b0000;
      en_mask       = m;
      start_r[inst] = 1'b1;
      @(posedge clk); #1;
      start_r[inst] = 1'b0;
      for (int t = 0; t < lat; t++) begin
         if (disturb && t == 1) begin start_r[inst] = 1'b1; en_mask = ~m; end
         if (disturb && t == 2) start_r[inst] = 1'b0;
         n_checks++;
         if (valid_w[inst] !== 1'b0 || busy_w[inst] !== 1'b1)
            $display("FAIL %s busy/valid t=%0d: busy=%b valid=%b expected busy=1 valid=0",
                     name, t, busy_w[inst], valid_w[inst]);
         else n_pass++;
         if (n > 0 && t < lat - 1) begin
            ch = ch_at(m, t / (s + 1));
            n_checks++;
            if (sel_w[inst] !== 2'(ch))
               $display("FAIL %s select t=%0d: got %0d expected %0d", name, t, sel_w[inst], ch);
            else n_pass++;
            if ((t + 1) % (s + 1) == 0) exp[ch] = din[ch];
         end
         if (n == 0) begin
            n_checks++;
            if (sel_w[inst] !== 2'b00)
               $display("FAIL %s empty select: got %0d expected 0", name, sel_w[inst]);
            else n_pass++;
         end
         @(posedge clk); #1;
      end
      n_checks++;
      if (valid_w[inst] !== 1'b1 || busy_w[inst] !== 1'b0 || sample_w[inst] !== exp)
         $display("FAIL %s result: valid=%b busy=%b sample=%b expected valid=1 busy=0 sample=%b",
                  name, valid_w[inst], busy_w[inst], sample_w[inst], exp);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (valid_w[inst] !== 1'b0 || busy_w[inst] !== 1'b0 || sel_w[inst] !== 2'b00 ||
          sample_w[inst] !== exp)
         $display("FAIL %s after: valid=%b busy=%b sel=%0d sample=%b expected 0 0 0 %b",
                  name, valid_w[inst], busy_w[inst], sel_w[inst], sample_w[inst], exp);
      else n_pass++;
   endtask

   task automatic test_reset();
      start_r[0] = 1'b1; start_r[1] = 1'b1; en_mask = 4'b1111;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (sel_w[i] !== 2'b00 || busy_w[i] !== 1'b0 || valid_w[i] !== 1'b0 || sample_w[i] !== 4'b0)
            $display("FAIL reset inst%0d: sel=%0d busy=%b valid=%b sample=%b expected all zero",
                     i, sel_w[i], busy_w[i], valid_w[i], sample_w[i]);
         else n_pass++;
      end
      start_r[0] = 1'b0; start_r[1] = 1'b0; rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_full_scan();
      din = 4'b1101;
      run_scan(0, 4'b1111, 1'b0, "full_scan");
      n_checks++;
      if (sample_w[0] !== 4'b1101)
         $display("FAIL full_scan word: got %b expected 1101", sample_w[0]);
      else n_pass++;
   endtask

   task automatic test_sparse_mask();
      din = 4'b1111;
      run_scan(0, 4'b0101, 1'b0, "sparse_mask");
   endtask

   task automatic test_empty_mask();
      din = 4'b1111;
      run_scan(0, 4'b0000, 1'b0, "empty_mask");
   endtask

   task automatic test_start_while_busy();
      din = 4'b1111;
      run_scan(0, 4'b0011, 1'b1, "start_while_busy");
   endtask

   task automatic test_reset_abort();
      din = 4'b1111; en_mask = 4'b1111; start_r[0] = 1'b1;
      @(posedge clk); #1;
      start_r[0] = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_checks++;
      if (sel_w[0] !== 2'b00 || busy_w[0] !== 1'b0 || valid_w[0] !== 1'b0 || sample_w[0] !== 4'b0)
         $display("FAIL reset_abort: sel=%0d busy=%b valid=%b sample=%b expected all zero",
                  sel_w[0], busy_w[0], valid_w[0], sample_w[0]);
      else n_pass++;
      for (int t = 0; t < 10; t++) begin
         @(posedge clk); #1;
         n_checks++;
         if (valid_w[0] !== 1'b0 || busy_w[0] !== 1'b0)
            $display("FAIL reset_abort idle t=%0d: valid=%b busy=%b expected 0 0", t, valid_w[0], busy_w[0]);
         else n_pass++;
      end
      din = 4'b0110;
      run_scan(0, 4'b1111, 1'b0, "after_abort");
   endtask

   // SETTLE=0 continuous rescan: valid every 5 cycles, i0 raised before the second ch0 capture.
   task automatic test_cont_back_to_back();
      logic [3:0] exp_word;
      din = 4'b1010; en_mask = 4'b1111; cont_r[1] = 1'b1; start_r[1] = 1'b1;
      @(posedge clk); #1;
      start_r[1] = 1'b0;
      for (int t = 1; t <= 16; t++) begin
         @(posedge clk); #1;
         if (t == 5) din[0] = 1'b1;
         if (t == 11) cont_r[1] = 1'b0;
         n_checks++;
         if (valid_w[1] !== ((t % 5 == 0) && (t <= 15)) ||
             busy_w[1] !== ((t < 15) && (t % 5 != 0)))
            $display("FAIL cont t=%0d: valid=%b busy=%b expected %b %b", t, valid_w[1], busy_w[1],
                     (t % 5 == 0) && (t <= 15), (t < 15) && (t % 5 != 0));
         else n_pass++;
         if (t < 15 && t % 5 < 4) begin
            n_checks++;
            if (sel_w[1] !== 2'(t % 5))
               $display("FAIL cont select t=%0d: got %0d expected %0d", t, sel_w[1], t % 5);
            else n_pass++;
         end
         if (t % 5 == 0 && t <= 15) begin
            exp_word = (t == 5) ? 4'b1010 : 4'b1011;
            n_checks++;
            if (sample_w[1] !== exp_word)
               $display("FAIL cont sample t=%0d: got %b expected %b", t, sample_w[1], exp_word);
            else n_pass++;
         end
      end
   endtask

   task automatic test_random();
      int inst;
      for (int k = 0; k < 12; k++) begin
         inst = int'($urandom_range(0, 1));
         din  = 4'($urandom);
         run_scan(inst, 4'($urandom), 1'b0, "random");
      end
   endtask

   initial begin
      start_r[0] = 1'b0; start_r[1] = 1'b0;
      cont_r[0]  = 1'b0; cont_r[1]  = 1'b0;
      en_mask    = 4'b0000;
      din        = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_full_scan();
      test_sparse_mask();
      test_empty_mask();
      test_start_while_busy();
      test_reset_abort();
      test_cont_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete, expected finish before 500000");
      $fatal(1);
   end

endmodule
